// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for alu_arbiter.
// Latency: none, wires only.
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes travel here.
interface alu_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [8*NREQ-1:0] req_imm;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [7:0]        rsp_data;
  logic              rsp_zf;
  logic              rsp_cf;
  logic              rsp_err;

  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [7:0]        alu_imm;
  logic [2:0]        alu_control;
  logic              alu_execute;
  logic [7:0]        alu_out;
  logic              alu_zf;
  logic              alu_cf;

  // Arbiter side: owns req_ready, the response and the ALU operand/strobe lines.
  modport master (
    input  req_valid, req_op, req_a, req_b, req_imm, rsp_ready, alu_out, alu_zf, alu_cf,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_zf, rsp_cf, rsp_err,
           alu_a, alu_b, alu_imm, alu_control, alu_execute
  );

  // Environment side: requesters, response consumer and the ALU itself.
  modport slave (
    output req_valid, req_op, req_a, req_b, req_imm, rsp_ready, alu_out, alu_zf, alu_cf,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_zf, rsp_cf, rsp_err,
           alu_a, alu_b, alu_imm, alu_control, alu_execute
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between NREQ requesters, one op at a time.
// Latency: accept at edge T, alu_execute in cycle T+1, rsp_valid from T+3 (T+1 for illegal op).
// Backpressure: response held stable until rsp_ready; requests accepted only in IDLE.
module alu_arbiter #(
  parameter int NREQ = 2
) (
  input logic           clk,
  input logic           rst_n,
  alu_arbiter_if.master bus
);

  localparam logic [2:0] OP_SUB = 3'b111;
  localparam logic [2:0] OP_ILL = 3'b101;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t     state_q;
  logic [1:0] rr_q;
  logic [2:0] op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] imm_q;
  logic [1:0] id_q;
  logic       exec_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic       rsp_zf_q;
  logic       rsp_cf_q;
  logic       rsp_err_q;

  logic [3:0] valid_pad;
  logic [3:0] ready_pad;
  logic [1:0] cand;
  logic       grant_vld_d;
  logic [1:0] grant_d;
  logic [1:0] rr_d;
  logic [2:0] op_sel;
  logic [7:0] a_sel;
  logic [7:0] b_sel;
  logic [7:0] imm_sel;

  // Padding to four lanes lets a 2-bit index address every NREQ without width games.
  assign valid_pad = 4'(bus.req_valid);

  // Round-robin search: first valid requester at or above rr_q, wrapping mod NREQ.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_d     = 2'd0;
    cand        = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand = 2'((int'(rr_q) + k) % NREQ);
      if (!grant_vld_d && valid_pad[cand]) begin
        grant_vld_d = 1'b1;
        grant_d     = cand;
      end
    end
  end

  assign rr_d    = (grant_d == 2'(NREQ - 1)) ? 2'd0 : grant_d + 2'd1;
  assign op_sel  = bus.req_op[3*int'(grant_d) +: 3];
  assign a_sel   = bus.req_a[8*int'(grant_d) +: 8];
  assign b_sel   = bus.req_b[8*int'(grant_d) +: 8];
  assign imm_sel = bus.req_imm[8*int'(grant_d) +: 8];

  // Accept strobe to the granted requester; gated by reset so it reads 0 while held in reset.
  always_comb begin
    ready_pad = 4'b0000;
    if (rst_n && state_q == IDLE && grant_vld_d) begin
      ready_pad[grant_d] = 1'b1;
    end
  end

  assign bus.req_ready = ready_pad[NREQ-1:0];

  // Sequencer: grant/latch, execute strobe, result capture, response hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 2'd0;
      op_q        <= 3'd0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      imm_q       <= 8'd0;
      id_q        <= 2'd0;
      exec_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      rsp_zf_q    <= 1'b0;
      rsp_cf_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            op_q  <= op_sel;
            a_q   <= a_sel;
            b_q   <= b_sel;
            imm_q <= imm_sel;
            id_q  <= grant_d;
            rr_q  <= rr_d;
            if (op_sel == OP_ILL) begin
              // Illegal opcode never reaches the ALU; answer with an error right away.
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 8'd0;
              rsp_zf_q    <= 1'b0;
              rsp_cf_q    <= 1'b0;
            end else begin
              state_q <= ISSUE;
              exec_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          exec_q  <= 1'b0;
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          // Only SUB updates the ALU flags, so anything else would report stale values.
          rsp_data_q  <= bus.alu_out;
          rsp_zf_q    <= (op_q == OP_SUB) ? bus.alu_zf : 1'b0;
          rsp_cf_q    <= (op_q == OP_SUB) ? bus.alu_cf : 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_imm     = imm_q;
  assign bus.alu_control = op_q;
  assign bus.alu_execute = exec_q;

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_zf      = rsp_zf_q;
  assign bus.rsp_cf      = rsp_cf_q;
  assign bus.rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: NREQ=2 instance for function, NREQ=4 for round-robin.
// Latency: checks sampled 1 time unit after the rising edge.
// Backpressure: rsp_ready driven per scenario.
module tb_alu_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.NREQ(2)) i2();
  alu_arbiter_if #(.NREQ(4)) i4();

  alu_arbiter #(.NREQ(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(i2));
  alu_arbiter #(.NREQ(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(i4));

  assign i4.alu_out = 8'h00;
  assign i4.alu_zf  = 1'b0;
  assign i4.alu_cf  = 1'b0;

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, b, imm);
    case (op)
      3'b100:  return b;
      3'b110:  return a + b;
      3'b111:  return a - b;
      3'b000:  return ~(a & b);
      3'b001:  return a & b;
      3'b010:  return a ^ b;
      3'b011:  return a >> imm;
      default: return 8'h00;
    endcase
  endfunction

  // Stand-in ALU: registered result, flags touched only by SUB.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i2.alu_out <= 8'h00;
      i2.alu_zf  <= 1'b0;
      i2.alu_cf  <= 1'b0;
    end else if (i2.alu_execute) begin
      i2.alu_out <= alu_fn(i2.alu_control, i2.alu_a, i2.alu_b, i2.alu_imm);
      if (i2.alu_control == 3'b111) begin
        i2.alu_zf <= (i2.alu_a == i2.alu_b);
        i2.alu_cf <= (i2.alu_a < i2.alu_b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request on dut2, wait for its grant, return in the cycle after acceptance.
  task automatic send2(input int id, input logic [2:0] op, input logic [7:0] a, b, imm);
    int n;
    logic [1:0] exp_rdy;
    n = 0;
    exp_rdy = 2'b01 << id;
    i2.req_op[3*id +: 3]  = op;
    i2.req_a[8*id +: 8]   = a;
    i2.req_b[8*id +: 8]   = b;
    i2.req_imm[8*id +: 8] = imm;
    i2.req_valid[id]      = 1'b1;
    #1;
    while (i2.req_ready[id] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (i2.req_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL grant req%0d: got %b want %b after %0d cycles", id, i2.req_ready, exp_rdy, n);
    end
    tick();
    i2.req_valid[id] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({i2.rsp_valid, i2.alu_execute, i2.req_ready, i2.rsp_err, i2.rsp_zf, i2.rsp_cf} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 0", {i2.rsp_valid, i2.alu_execute, i2.req_ready,
               i2.rsp_err, i2.rsp_zf, i2.rsp_cf});
    end
    n_cmp++;
    if ({i2.rsp_data, i2.rsp_id, i2.alu_a, i2.alu_b, i2.alu_imm, i2.alu_control} !== 37'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0", {i2.rsp_data, i2.rsp_id, i2.alu_a, i2.alu_b,
               i2.alu_imm, i2.alu_control});
    end
    n_cmp++;
    if ({i4.rsp_valid, i4.alu_execute, i4.req_ready} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_nreq4: got %b want 0", {i4.rsp_valid, i4.alu_execute, i4.req_ready});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    i2.rsp_ready = 1'b1;
    send2(0, 3'b110, 8'h7F, 8'h01, 8'h00);
    n_cmp++;
    if ({i2.alu_execute, i2.req_ready} !== 3'b100) begin
      n_err++;
      $display("FAIL add_issue: exec/ready got %b want 100", {i2.alu_execute, i2.req_ready});
    end
    n_cmp++;
    if ({i2.alu_control, i2.alu_a, i2.alu_b} !== {3'b110, 8'h7F, 8'h01}) begin
      n_err++;
      $display("FAIL add_operands: got %h want %h", {i2.alu_control, i2.alu_a, i2.alu_b},
               {3'b110, 8'h7F, 8'h01});
    end
    tick();
    n_cmp++;
    if ({i2.alu_execute, i2.rsp_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL add_capture: exec/rsp_valid got %b want 00", {i2.alu_execute, i2.rsp_valid});
    end
    tick();
    n_cmp++;
    if ({i2.rsp_valid, i2.rsp_id, i2.rsp_data, i2.rsp_zf, i2.rsp_cf, i2.rsp_err} !==
        {1'b1, 2'd0, 8'h80, 3'b000}) begin
      n_err++;
      $display("FAIL add_rsp: got %h want %h", {i2.rsp_valid, i2.rsp_id, i2.rsp_data, i2.rsp_zf,
               i2.rsp_cf, i2.rsp_err}, {1'b1, 2'd0, 8'h80, 3'b000});
    end
    tick();
    n_cmp++;
    if ({i2.rsp_valid, i2.alu_execute} !== 2'b00) begin
      n_err++;
      $display("FAIL add_done: rsp_valid/exec got %b want 00", {i2.rsp_valid, i2.alu_execute});
    end
  endtask

  task automatic test_sub_flags();
    logic [2:0]  op [3];
    logic [7:0]  a [3];
    logic [7:0]  b [3];
    logic [13:0] exp_rsp [3];
    op = '{3'b111, 3'b111, 3'b001};
    a  = '{8'h05, 8'h03, 8'hF0};
    b  = '{8'h05, 8'h04, 8'h3C};
    exp_rsp = '{{1'b1, 2'd1, 8'h00, 3'b100},
                {1'b1, 2'd1, 8'hFF, 3'b010},
                {1'b1, 2'd1, 8'h30, 3'b000}};
    i2.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send2(1, op[i], a[i], b[i], 8'h00);
      tick();
      tick();
      n_cmp++;
      if ({i2.rsp_valid, i2.rsp_id, i2.rsp_data, i2.rsp_zf, i2.rsp_cf, i2.rsp_err} !== exp_rsp[i]) begin
        n_err++;
        $display("FAIL sub_flags[%0d]: got %h want %h", i, {i2.rsp_valid, i2.rsp_id, i2.rsp_data,
                 i2.rsp_zf, i2.rsp_cf, i2.rsp_err}, exp_rsp[i]);
      end
      tick();
    end
  endtask

  task automatic test_ops();
    logic [2:0] op [4];
    logic [7:0] a [4];
    logic [7:0] b [4];
    logic [7:0] imm [4];
    logic [7:0] exp_d [4];
    op    = '{3'b100, 3'b000, 3'b010, 3'b011};
    a     = '{8'h11, 8'hF0, 8'hF0, 8'h80};
    b     = '{8'h5A, 8'h3C, 8'h3C, 8'h00};
    imm   = '{8'h00, 8'h00, 8'h00, 8'h03};
    exp_d = '{8'h5A, 8'hCF, 8'hCC, 8'h10};
    i2.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send2(i % 2, op[i], a[i], b[i], imm[i]);
      tick();
      tick();
      n_cmp++;
      if ({i2.rsp_valid, i2.rsp_id, i2.rsp_data, i2.rsp_zf, i2.rsp_cf, i2.rsp_err} !==
          {1'b1, 2'(i % 2), exp_d[i], 3'b000}) begin
        n_err++;
        $display("FAIL ops[%0d]: got %h want %h", i, {i2.rsp_valid, i2.rsp_id, i2.rsp_data,
                 i2.rsp_zf, i2.rsp_cf, i2.rsp_err}, {1'b1, 2'(i % 2), exp_d[i], 3'b000});
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] g2 [$];
    logic [3:0] g4 [$];
    int         t2 [$];
    int         t4 [$];
    logic [1:0] exp2 [4];
    logic [3:0] exp4 [4];
    logic [1:0] got2;
    logic [3:0] got4;
    int         gap2;
    int         gap4;
    exp2 = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp4 = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    i2.req_op  = {3'b110, 3'b110};
    i2.req_a   = {8'h01, 8'h02};
    i2.req_b   = {8'h03, 8'h04};
    i2.rsp_ready = 1'b1;
    i4.rsp_ready = 1'b1;
    i4.req_op  = {4{3'b110}};
    i2.req_valid = 2'b11;
    i4.req_valid = 4'b1010;
    #1;
    for (int c = 0; c < 24; c++) begin
      if (i2.req_ready != 2'b00 && g2.size() < 4) begin
        g2.push_back(i2.req_ready);
        t2.push_back(c);
      end
      if (i4.req_ready != 4'b0000 && g4.size() < 4) begin
        g4.push_back(i4.req_ready);
        t4.push_back(c);
      end
      tick();
    end
    i2.req_valid = 2'b00;
    i4.req_valid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      got2 = (k < g2.size()) ? g2[k] : 2'bxx;
      got4 = (k < g4.size()) ? g4[k] : 4'bxxxx;
      n_cmp++;
      if (got2 !== exp2[k]) begin
        n_err++;
        $display("FAIL rr2_grant[%0d]: got %b want %b", k, got2, exp2[k]);
      end
      n_cmp++;
      if (got4 !== exp4[k]) begin
        n_err++;
        $display("FAIL rr4_grant[%0d]: got %b want %b", k, got4, exp4[k]);
      end
    end
    gap2 = (t2.size() >= 2) ? t2[1] - t2[0] : -1;
    gap4 = (t4.size() >= 2) ? t4[1] - t4[0] : -1;
    n_cmp++;
    if (gap2 !== 4) begin
      n_err++;
      $display("FAIL rr2_period: got %0d cycles want 4", gap2);
    end
    n_cmp++;
    if (gap4 !== 4) begin
      n_err++;
      $display("FAIL rr4_period: got %0d cycles want 4", gap4);
    end
    repeat (5) tick();
  endtask

  task automatic test_backpressure();
    i2.rsp_ready = 1'b0;
    send2(0, 3'b110, 8'h10, 8'h20, 8'h00);
    i2.req_op[5:3]  = 3'b010;
    i2.req_a[15:8]  = 8'h0F;
    i2.req_b[15:8]  = 8'hFF;
    i2.req_valid[1] = 1'b1;
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({i2.rsp_valid, i2.rsp_id, i2.rsp_data, i2.rsp_zf, i2.rsp_cf, i2.rsp_err} !==
          {1'b1, 2'd0, 8'h30, 3'b000}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got %h want %h", c, {i2.rsp_valid, i2.rsp_id, i2.rsp_data,
                 i2.rsp_zf, i2.rsp_cf, i2.rsp_err}, {1'b1, 2'd0, 8'h30, 3'b000});
      end
      n_cmp++;
      if ({i2.alu_execute, i2.req_ready} !== 3'b000) begin
        n_err++;
        $display("FAIL bp_quiet[%0d]: exec/ready got %b want 000", c, {i2.alu_execute, i2.req_ready});
      end
      if (c < 4) tick();
    end
    i2.rsp_ready = 1'b1;
    tick();
    n_cmp++;
    if ({i2.rsp_valid, i2.req_ready} !== 3'b010) begin
      n_err++;
      $display("FAIL bp_release: rsp_valid/ready got %b want 010", {i2.rsp_valid, i2.req_ready});
    end
    tick();
    i2.req_valid[1] = 1'b0;
    n_cmp++;
    if (i2.alu_execute !== 1'b1) begin
      n_err++;
      $display("FAIL bp_next_exec: got %b want 1", i2.alu_execute);
    end
    tick();
    tick();
    n_cmp++;
    if ({i2.rsp_valid, i2.rsp_id, i2.rsp_data, i2.rsp_zf, i2.rsp_cf, i2.rsp_err} !==
        {1'b1, 2'd1, 8'hF0, 3'b000}) begin
      n_err++;
      $display("FAIL bp_next_rsp: got %h want %h", {i2.rsp_valid, i2.rsp_id, i2.rsp_data,
               i2.rsp_zf, i2.rsp_cf, i2.rsp_err}, {1'b1, 2'd1, 8'hF0, 3'b000});
    end
    tick();
  endtask

  task automatic test_illegal();
    i2.rsp_ready = 1'b1;
    send2(0, 3'b101, 8'h55, 8'hAA, 8'h07);
    n_cmp++;
    if ({i2.rsp_valid, i2.rsp_id, i2.rsp_data, i2.rsp_zf, i2.rsp_cf, i2.rsp_err} !==
        {1'b1, 2'd0, 8'h00, 3'b001}) begin
      n_err++;
      $display("FAIL ill_rsp: got %h want %h", {i2.rsp_valid, i2.rsp_id, i2.rsp_data, i2.rsp_zf,
               i2.rsp_cf, i2.rsp_err}, {1'b1, 2'd0, 8'h00, 3'b001});
    end
    n_cmp++;
    if (i2.alu_execute !== 1'b0) begin
      n_err++;
      $display("FAIL ill_no_exec: got %b want 0", i2.alu_execute);
    end
    tick();
    n_cmp++;
    if ({i2.rsp_valid, i2.alu_execute} !== 2'b00) begin
      n_err++;
      $display("FAIL ill_done: rsp_valid/exec got %b want 00", {i2.rsp_valid, i2.alu_execute});
    end
    send2(1, 3'b110, 8'h01, 8'h02, 8'h00);
    tick();
    tick();
    n_cmp++;
    if ({i2.rsp_valid, i2.rsp_id, i2.rsp_data, i2.rsp_zf, i2.rsp_cf, i2.rsp_err} !==
        {1'b1, 2'd1, 8'h03, 3'b000}) begin
      n_err++;
      $display("FAIL ill_after: got %h want %h", {i2.rsp_valid, i2.rsp_id, i2.rsp_data, i2.rsp_zf,
               i2.rsp_cf, i2.rsp_err}, {1'b1, 2'd1, 8'h03, 3'b000});
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    i2.rsp_ready = 1'b1;
    i2.req_op[5:3] = 3'b110;
    i2.req_a[15:8] = 8'h01;
    i2.req_b[15:8] = 8'h02;
    send2(0, 3'b110, 8'h01, 8'h01, 8'h00);
    n_cmp++;
    if (i2.alu_execute !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre_issue: exec got %b want 1", i2.alu_execute);
    end
    i2.req_valid = 2'b11;
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({i2.rsp_valid, i2.alu_execute, i2.req_ready} !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_async: got %b want 0000", {i2.rsp_valid, i2.alu_execute, i2.req_ready});
    end
    tick();
    n_cmp++;
    if ({i2.rsp_valid, i2.alu_execute, i2.req_ready} !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_held: got %b want 0000", {i2.rsp_valid, i2.alu_execute, i2.req_ready});
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (i2.req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL rst_rr: got %b want 01", i2.req_ready);
    end
    tick();
    i2.req_valid = 2'b00;
    n_cmp++;
    if ({i2.alu_execute, i2.rsp_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_next_issue: exec/rsp_valid got %b want 10", {i2.alu_execute, i2.rsp_valid});
    end
    tick();
    tick();
    n_cmp++;
    if ({i2.rsp_valid, i2.rsp_id, i2.rsp_data, i2.rsp_zf, i2.rsp_cf, i2.rsp_err} !==
        {1'b1, 2'd0, 8'h02, 3'b000}) begin
      n_err++;
      $display("FAIL rst_next_rsp: got %h want %h", {i2.rsp_valid, i2.rsp_id, i2.rsp_data,
               i2.rsp_zf, i2.rsp_cf, i2.rsp_err}, {1'b1, 2'd0, 8'h02, 3'b000});
    end
    tick();
  endtask

  initial begin
    i2.req_valid = '0;
    i2.req_op    = '0;
    i2.req_a     = '0;
    i2.req_b     = '0;
    i2.req_imm   = '0;
    i2.rsp_ready = 1'b0;
    i4.req_valid = '0;
    i4.req_op    = '0;
    i4.req_a     = '0;
    i4.req_b     = '0;
    i4.req_imm   = '0;
    i4.rsp_ready = 1'b0;

    test_reset();
    test_add();
    test_sub_flags();
    test_ops();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_reset_mid_op();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared so far", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
